sdio_cd_debounce: RTL and testbench
===================================

Name: sdio_cd_debounce

Overview:
Debounce and event stage for the SDIO card-detect / write-protect pin. It sits directly downstream of the two-flop synchroniser/edge-detector and consumes its synchronised level plus its rise/fall pulses. It filters bounce with a programmable hold time, exposes a stable level and card-present flag, and raises sticky insert/remove interrupts with glitch statistics for the SDIO register file.

Parameters:
CNT_W, 16, width of the debounce counter and of the debounce_cfg_i hold-time field.
GLITCH_W, 8, width of the saturating glitch counter.

Ports:
clk_i  input  1  clock
rstn_i  input  1  reset, asynchronous, active-low
en_i  input  1  filter enable
serial_i  input  1  synchronised pin level, from the edge detector
r_edge_i  input  1  rising-edge pulse, one cycle, from the edge detector
f_edge_i  input  1  falling-edge pulse, one cycle, from the edge detector
debounce_cfg_i  input  CNT_W  hold time in cycles, minus 1
polarity_i  input  1  0: high level means card present; 1: low level means card present
irq_en_i  input  2  bit0 enables insert irq, bit1 enables remove irq
irq_clr_i  input  2  write-1 pulse clearing pending bit0 (insert) and bit1 (remove)
level_o  output  1  debounced level
present_o  output  1  level_o XOR polarity_i
insert_o  output  1  one-cycle pulse when present_o goes 0->1
remove_o  output  1  one-cycle pulse when present_o goes 1->0
pend_o  output  2  sticky pending bits {remove, insert}
irq_o  output  1  |(pend_o & irq_en_i)
busy_o  output  1  high while in a WAIT state
glitch_cnt_o  output  GLITCH_W  count of aborted transitions, saturating

Behaviour:
- Reset values: state STABLE_LO, counter 0, level_o 0, insert_o 0, remove_o 0, pend_o 0, glitch_cnt_o 0, busy_o 0.
- present_o and irq_o are combinational from registers and inputs. All other outputs are registered.
- FSM states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
- STABLE_LO -> WAIT_HI when en_i=1 and (r_edge_i=1 or serial_i=1). The serial_i term is the resync path after disable. Counter is loaded with debounce_cfg_i.
- STABLE_HI -> WAIT_LO: the same rule using f_edge_i or serial_i=0.
- In a stable state with en_i=0: edges are ignored and the state is held.
- WAIT_HI abort: if f_edge_i=1 or serial_i=0, go to STABLE_LO and increment glitch_cnt_o (saturating at all-ones). No events. WAIT_LO aborts symmetrically.
- WAIT_x with en_i=0: return to the prior stable state. No glitch increment, no event.
- WAIT_x commit: if counter==0 and no abort, go to STABLE_x and update level_o. Otherwise decrement the counter.
  - Abort has priority over commit.
  - Latency: edge sampled at clock N means level_o changes at clock N+1+debounce_cfg_i+1 (cfg=0 gives 2 cycles).
- debounce_cfg_i is sampled only at WAIT entry. Changes mid-wait have no effect.
- Events: on commit, insert_o or remove_o pulses in the same cycle level_o updates, selected by the new present value under the current polarity_i.
  - A polarity_i change alone changes present_o but generates no event.
- Pending bits: set on the event pulse, cleared by the matching irq_clr_i bit. Set wins over a simultaneous clear.
- irq_o is level, not pulse. It stays high until the pending bit is cleared or the enable is dropped.
- Reset mid-WAIT: immediate return to the reset values above. A high pin after reset re-enters WAIT_HI via the serial_i term.

Test Plan:
1. Reset, en=1, cfg=3, single rise at cycle 10 and held high -> level_o=1 at cycle 15; insert_o pulse at cycle 15; pend_o=01; irq_o=1 with irq_en=01.
2. cfg=7; rise, fall 3 cycles later, rise again and held -> glitch_cnt_o=1; busy_o high through; single insert_o 9 cycles after the second rise.
3. Stable high, polarity=0; fall held -> remove_o pulse; pend_o=11. irq_clr_i=01 -> pend_o=10. irq_clr_i=10 in the same cycle as a new remove event -> pend_o bit1 stays 1.
4. en_i=0 during WAIT_HI -> back to STABLE_LO, no event, glitch_cnt_o unchanged. Pin held high, en_i re-asserted -> commit after cfg+2 cycles with no edge pulse present.
5. 300 bounce pulses with GLITCH_W=8 -> glitch_cnt_o saturates at 255, no events.
6. rstn_i asserted mid-WAIT_LO with cfg=100 -> all outputs 0 asynchronously. Pin high after release -> level_o=1 after 102 cycles.

Source files
------------

// File: rtl/sdio_cd_debounce.sv
// -----------------------------------------------------------------------------
// sdio_cd_debounce
//
// Debounce and event stage for the SDIO card-detect / write-protect pin.
// Consumes the synchronised pin level and its rise/fall pulses from the
// upstream two-flop synchroniser / edge detector. A transition is accepted
// only after the pin has held its new level for debounce_cfg_i+1 cycles in
// a WAIT state. The block then updates the debounced level, emits an
// insert/remove pulse and sets a sticky pending bit for the register file.
//
// Ports:
//   clk_i          clock
//   rstn_i         asynchronous active-low reset
//   en_i           filter enable; when low, stable states hold and any
//                  in-progress wait falls back to its prior stable state
//   serial_i       synchronised pin level
//   r_edge_i       one-cycle rising-edge pulse
//   f_edge_i       one-cycle falling-edge pulse
//   debounce_cfg_i hold time in cycles minus 1, sampled at WAIT entry
//   polarity_i     0: high = card present, 1: low = card present
//   irq_en_i       {remove, insert} interrupt enables
//   irq_clr_i      {remove, insert} write-1 clear pulses for pend_o
//   level_o        debounced level (registered)
//   present_o      level_o ^ polarity_i (combinational)
//   insert_o       one-cycle pulse when present goes 0->1 on a commit
//   remove_o       one-cycle pulse when present goes 1->0 on a commit
//   pend_o         sticky pending bits {remove, insert}
//   irq_o          |(pend_o & irq_en_i) (combinational)
//   busy_o         high while in a WAIT state (registered)
//   glitch_cnt_o   saturating count of aborted transitions
// -----------------------------------------------------------------------------
module sdio_cd_debounce #(
  parameter int CNT_W    = 16,
  parameter int GLITCH_W = 8
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                en_i,
  input  logic                serial_i,
  input  logic                r_edge_i,
  input  logic                f_edge_i,
  input  logic [CNT_W-1:0]    debounce_cfg_i,
  input  logic                polarity_i,
  input  logic [1:0]          irq_en_i,
  input  logic [1:0]          irq_clr_i,
  output logic                level_o,
  output logic                present_o,
  output logic                insert_o,
  output logic                remove_o,
  output logic [1:0]          pend_o,
  output logic                irq_o,
  output logic                busy_o,
  output logic [GLITCH_W-1:0] glitch_cnt_o
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                level_reg, level_next;
  logic                insert_reg, insert_next;
  logic                remove_reg, remove_next;
  logic [1:0]          pend_reg, pend_next;
  logic                busy_reg, busy_next;
  logic [GLITCH_W-1:0] glitch_reg, glitch_next;

  logic                commit;
  logic                abort;
  logic                new_present;

  // State register and all registered outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg  <= STABLE_LO;
      cnt_reg    <= '0;
      level_reg  <= 1'b0;
      insert_reg <= 1'b0;
      remove_reg <= 1'b0;
      pend_reg   <= 2'b00;
      busy_reg   <= 1'b0;
      glitch_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      level_reg  <= level_next;
      insert_reg <= insert_next;
      remove_reg <= remove_next;
      pend_reg   <= pend_next;
      busy_reg   <= busy_next;
      glitch_reg <= glitch_next;
    end
  end

  // Next-state logic. Inside a WAIT state the priority is:
  // disable (silent fall-back) > abort (glitch) > commit > count down.
  // The serial_i terms in the stable states let the filter resync to a pin
  // that moved while the filter was disabled or held in reset.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    commit     = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      STABLE_LO: begin
        if (en_i && (r_edge_i || serial_i)) begin
          state_next = WAIT_HI;
          cnt_next   = debounce_cfg_i;
        end
      end
      STABLE_HI: begin
        if (en_i && (f_edge_i || !serial_i)) begin
          state_next = WAIT_LO;
          cnt_next   = debounce_cfg_i;
        end
      end
      WAIT_HI: begin
        if (!en_i) begin
          state_next = STABLE_LO;
        end else if (f_edge_i || !serial_i) begin
          state_next = STABLE_LO;
          abort      = 1'b1;
        end else if (cnt_reg == '0) begin
          state_next = STABLE_HI;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      WAIT_LO: begin
        if (!en_i) begin
          state_next = STABLE_HI;
        end else if (r_edge_i || serial_i) begin
          state_next = STABLE_HI;
          abort      = 1'b1;
        end else if (cnt_reg == '0) begin
          state_next = STABLE_LO;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: begin
        state_next = STABLE_LO;
      end
    endcase
  end

  // Output logic.
  always_comb begin
    level_next = level_reg;
    if (commit) begin
      level_next = (state_next == STABLE_HI);
    end

    // Event direction follows the present value after the commit, under the
    // current polarity, so a polarity flip on its own never raises an event.
    new_present = level_next ^ polarity_i;
    insert_next = commit && new_present;
    remove_next = commit && !new_present;

    // Pending bits are set from the registered event pulses, so a clear that
    // lands in the cycle the pulse is visible loses against the set.
    pend_next = (pend_reg & ~irq_clr_i) | {remove_reg, insert_reg};

    glitch_next = glitch_reg;
    if (abort && (glitch_reg != {GLITCH_W{1'b1}})) begin
      glitch_next = glitch_reg + GLITCH_W'(1);
    end

    busy_next = (state_next == WAIT_HI) || (state_next == WAIT_LO);
  end

  assign level_o      = level_reg;
  assign present_o    = level_reg ^ polarity_i;
  assign insert_o     = insert_reg;
  assign remove_o     = remove_reg;
  assign pend_o       = pend_reg;
  assign irq_o        = |(pend_reg & irq_en_i);
  assign busy_o       = busy_reg;
  assign glitch_cnt_o = glitch_reg;

endmodule

// File: tb/tb_sdio_cd_debounce.sv
// -----------------------------------------------------------------------------
// tb_sdio_cd_debounce
//
// Directed bench for sdio_cd_debounce: a per-cycle vector table covering
// insert/remove commits, pending set/clear and polarity, followed by
// hand-written sequences for glitch abort, disable during wait, glitch
// saturation and reset in the middle of a long wait.
// -----------------------------------------------------------------------------
module tb_sdio_cd_debounce;

  localparam int CNT_W    = 16;
  localparam int GLITCH_W = 8;

  logic                clk_i = 1'b0;
  logic                rstn_i = 1'b1;
  logic                en_i;
  logic                serial_i;
  logic                r_edge_i;
  logic                f_edge_i;
  logic [CNT_W-1:0]    debounce_cfg_i;
  logic                polarity_i;
  logic [1:0]          irq_en_i;
  logic [1:0]          irq_clr_i;
  logic                level_o;
  logic                present_o;
  logic                insert_o;
  logic                remove_o;
  logic [1:0]          pend_o;
  logic                irq_o;
  logic                busy_o;
  logic [GLITCH_W-1:0] glitch_cnt_o;

  sdio_cd_debounce #(
    .CNT_W    (CNT_W),
    .GLITCH_W (GLITCH_W)
  ) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .en_i           (en_i),
    .serial_i       (serial_i),
    .r_edge_i       (r_edge_i),
    .f_edge_i       (f_edge_i),
    .debounce_cfg_i (debounce_cfg_i),
    .polarity_i     (polarity_i),
    .irq_en_i       (irq_en_i),
    .irq_clr_i      (irq_clr_i),
    .level_o        (level_o),
    .present_o      (present_o),
    .insert_o       (insert_o),
    .remove_o       (remove_o),
    .pend_o         (pend_o),
    .irq_o          (irq_o),
    .busy_o         (busy_o),
    .glitch_cnt_o   (glitch_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       serial;
    logic       r_edge;
    logic       f_edge;
    logic       pol;
    logic [1:0] clr;
    logic       level;
    logic       present;
    logic       ins;
    logic       rem;
    logic [1:0] pend;
    logic       irq;
    logic       busy;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic s, input logic r, input logic f, input logic p,
                     input logic [1:0] c, input logic l, input logic pr,
                     input logic i, input logic rm, input logic [1:0] pd,
                     input logic q, input logic b);
    vec_t v;
    v.serial = s; v.r_edge = r; v.f_edge = f; v.pol = p; v.clr = c;
    v.level = l; v.present = pr; v.ins = i; v.rem = rm; v.pend = pd;
    v.irq = q; v.busy = b;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drive the pin to lvl with a one-cycle edge pulse and wait (bounded) for
  // the debounced level to follow.
  task automatic settle(input logic lvl);
    serial_i = lvl;
    if (lvl) r_edge_i = 1'b1;
    else     f_edge_i = 1'b1;
    for (int k = 0; k < 300 && level_o !== lvl; k++) begin
      tick();
      r_edge_i = 1'b0;
      f_edge_i = 1'b0;
    end
    r_edge_i = 1'b0;
    f_edge_i = 1'b0;
    chk("settle level", level_o, lvl);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ins_cnt;
    int ev;
    logic seen;
    logic busy_all;

    en_i = 1'b1; serial_i = 1'b0; r_edge_i = 1'b0; f_edge_i = 1'b0;
    debounce_cfg_i = 16'd3; polarity_i = 1'b0; irq_en_i = 2'b01; irq_clr_i = 2'b00;

    // ---------------- reset ----------------
    #2 rstn_i = 1'b0;
    tick(); tick();
    chk("reset level", level_o, 0);
    chk("reset pend", pend_o, 0);
    chk("reset busy", busy_o, 0);
    chk("reset glitch", glitch_cnt_o, 0);
    chk("reset insert", insert_o, 0);
    rstn_i = 1'b1;

    // ---------------- vector table, cfg=3, polarity 0 ----------------
    //   s  r  f  p  clr   | lvl prs ins rem pend irq busy
    add(0, 0, 0, 0, 2'b00,   0,  0,  0,  0, 2'b00, 0, 0);
    add(1, 1, 0, 0, 2'b00,   0,  0,  0,  0, 2'b00, 0, 1);   // rise -> WAIT_HI
    for (int k = 0; k < 3; k++)
      add(1, 0, 0, 0, 2'b00, 0,  0,  0,  0, 2'b00, 0, 1);
    add(1, 0, 0, 0, 2'b00,   1,  1,  1,  0, 2'b00, 0, 0);   // commit, insert
    add(1, 0, 0, 0, 2'b00,   1,  1,  0,  0, 2'b01, 1, 0);   // pend follows pulse
    add(0, 0, 1, 0, 2'b00,   1,  1,  0,  0, 2'b01, 1, 1);   // fall -> WAIT_LO
    for (int k = 0; k < 3; k++)
      add(0, 0, 0, 0, 2'b00, 1,  1,  0,  0, 2'b01, 1, 1);
    add(0, 0, 0, 0, 2'b00,   0,  0,  0,  1, 2'b01, 1, 0);   // commit, remove
    add(0, 0, 0, 0, 2'b00,   0,  0,  0,  0, 2'b11, 1, 0);
    add(0, 0, 0, 0, 2'b01,   0,  0,  0,  0, 2'b10, 0, 0);   // clear insert
    add(1, 1, 0, 0, 2'b00,   0,  0,  0,  0, 2'b10, 0, 1);
    for (int k = 0; k < 3; k++)
      add(1, 0, 0, 0, 2'b00, 0,  0,  0,  0, 2'b10, 0, 1);
    add(1, 0, 0, 0, 2'b00,   1,  1,  1,  0, 2'b10, 0, 0);
    add(1, 0, 0, 0, 2'b00,   1,  1,  0,  0, 2'b11, 1, 0);
    add(0, 0, 1, 0, 2'b00,   1,  1,  0,  0, 2'b11, 1, 1);
    for (int k = 0; k < 3; k++)
      add(0, 0, 0, 0, 2'b00, 1,  1,  0,  0, 2'b11, 1, 1);
    add(0, 0, 0, 0, 2'b00,   0,  0,  0,  1, 2'b11, 1, 0);   // remove pulse
    add(0, 0, 0, 0, 2'b10,   0,  0,  0,  0, 2'b11, 1, 0);   // set beats clear
    add(0, 0, 0, 0, 2'b10,   0,  0,  0,  0, 2'b01, 1, 0);   // now clears
    add(0, 0, 0, 1, 2'b00,   0,  1,  0,  0, 2'b01, 1, 0);   // polarity only
    add(0, 0, 0, 0, 2'b00,   0,  0,  0,  0, 2'b01, 1, 0);

    for (int i = 0; i < vq.size(); i++) begin
      serial_i = vq[i].serial; r_edge_i = vq[i].r_edge; f_edge_i = vq[i].f_edge;
      polarity_i = vq[i].pol; irq_clr_i = vq[i].clr;
      tick();
      chk($sformatf("row%0d level", i), level_o, vq[i].level);
      chk($sformatf("row%0d present", i), present_o, vq[i].present);
      chk($sformatf("row%0d insert", i), insert_o, vq[i].ins);
      chk($sformatf("row%0d remove", i), remove_o, vq[i].rem);
      chk($sformatf("row%0d pend", i), pend_o, vq[i].pend);
      chk($sformatf("row%0d irq", i), irq_o, vq[i].irq);
      chk($sformatf("row%0d busy", i), busy_o, vq[i].busy);
    end
    r_edge_i = 1'b0; f_edge_i = 1'b0; irq_clr_i = 2'b00; polarity_i = 1'b0;
    chk("table glitch", glitch_cnt_o, 0);

    // ---------------- glitch abort, cfg=7 ----------------
    debounce_cfg_i = 16'd7;
    serial_i = 1'b1; r_edge_i = 1'b1;
    tick();
    r_edge_i = 1'b0;
    tick(); tick();
    serial_i = 1'b0; f_edge_i = 1'b1;
    tick();
    f_edge_i = 1'b0;
    chk("t2 glitch", glitch_cnt_o, 1);
    chk("t2 level after abort", level_o, 0);
    serial_i = 1'b1; r_edge_i = 1'b1;
    n = 0; seen = 1'b0; busy_all = 1'b1; ins_cnt = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      r_edge_i = 1'b0;
      n++;
      if (insert_o) begin
        seen = 1'b1;
        ins_cnt++;
      end else if (!busy_o) begin
        busy_all = 1'b0;
      end
    end
    chk("t2 insert latency", n, 9);
    chk("t2 busy during wait", busy_all, 1);
    repeat (10) begin
      tick();
      if (insert_o) ins_cnt++;
    end
    chk("t2 insert count", ins_cnt, 1);

    // ---------------- disable during WAIT_HI ----------------
    settle(1'b0);
    debounce_cfg_i = 16'd5;
    serial_i = 1'b1; r_edge_i = 1'b1;
    tick();
    r_edge_i = 1'b0;
    tick();
    chk("t4 busy in wait", busy_o, 1);
    en_i = 1'b0;
    tick();
    chk("t4 busy after disable", busy_o, 0);
    chk("t4 level after disable", level_o, 0);
    chk("t4 glitch unchanged", glitch_cnt_o, 1);
    ev = 0;
    repeat (3) begin
      tick();
      if (insert_o || remove_o || busy_o) ev++;
    end
    chk("t4 quiet while disabled", ev, 0);
    en_i = 1'b1;
    n = 0;
    for (int k = 0; k < 40 && level_o !== 1'b1; k++) begin
      tick();
      n++;
    end
    chk("t4 resync latency", n, 7);
    chk("t4 resync insert", insert_o, 1);

    // ---------------- glitch saturation ----------------
    settle(1'b0);
    debounce_cfg_i = 16'd3;
    ev = 0;
    repeat (300) begin
      serial_i = 1'b1; r_edge_i = 1'b1;
      tick();
      if (insert_o || remove_o) ev++;
      serial_i = 1'b0; r_edge_i = 1'b0; f_edge_i = 1'b1;
      tick();
      f_edge_i = 1'b0;
      if (insert_o || remove_o) ev++;
    end
    chk("t5 glitch saturated", glitch_cnt_o, 255);
    chk("t5 no events", ev, 0);

    // ---------------- async reset in WAIT_LO, cfg=100 ----------------
    settle(1'b1);
    debounce_cfg_i = 16'd100;
    serial_i = 1'b0; f_edge_i = 1'b1;
    tick();
    f_edge_i = 1'b0;
    tick(); tick();
    chk("t6 busy before reset", busy_o, 1);
    chk("t6 pend before reset", pend_o, 3);
    #2 rstn_i = 1'b0;
    #1;
    chk("t6 async level", level_o, 0);
    chk("t6 async present", present_o, 0);
    chk("t6 async insert", insert_o, 0);
    chk("t6 async remove", remove_o, 0);
    chk("t6 async pend", pend_o, 0);
    chk("t6 async irq", irq_o, 0);
    chk("t6 async busy", busy_o, 0);
    chk("t6 async glitch", glitch_cnt_o, 0);
    serial_i = 1'b1;
    tick();
    rstn_i = 1'b1;
    n = 0;
    for (int k = 0; k < 200 && level_o !== 1'b1; k++) begin
      tick();
      n++;
    end
    chk("t6 post-reset latency", n, 102);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
